// File: rtl/dc_filter_pkg.sv
`default_nettype none
// ==== dc_filter_pkg : state type, width defaults and saturation helpers (rev 1.0) ====
package dc_filter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    TRACK  = 2'd2,
    FREEZE = 2'd3
  } dc_state_e;

  localparam int IN_W_DEF  = 9;
  localparam int ACC_W_DEF = 32;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_in(input logic signed [63:0] v, input int w = IN_W_DEF);
    return sat_signed(v, w);
  endfunction

  function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v, input int w = ACC_W_DEF);
    return sat_signed(v, w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dc_acc_bank.sv
`default_nettype none
// ==== dc_acc_bank : per-channel DC accumulators, one shared read/write port (rev 1.0) ====
module dc_acc_bank #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [ACC_W-1:0] wdata,
  output logic signed [ACC_W-1:0] rdata
);

  logic signed [ACC_W-1:0] r_acc [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_CH; i++)
        if (idx == IDX_W'(i)) r_acc[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (idx == IDX_W'(i)) rdata = r_acc[i];
  end

endmodule
`default_nettype wire

// File: rtl/dc_filter_sched.sv
`default_nettype none
// ==== dc_filter_sched : time-multiplexed DC-removal scheduler with 3.072 MHz strobe (rev 1.0) ====
module dc_filter_sched
  import dc_filter_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DIV           = 8,
  parameter int IN_W          = IN_W_DEF,
  parameter int ACC_W         = ACC_W_DEF,
  parameter int K_FAST        = 6,
  parameter int K_SLOW        = 14,
  parameter int SETTLE_FRAMES = 4096
) (
  input  logic                     CLK_24M,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     restart,
  input  logic                     freeze,
  input  logic [NUM_CH*IN_W-1:0]   c_data,
  output logic                     enable_3M,
  output logic [NUM_CH*IN_W-1:0]   o_data,
  output logic                     o_valid,
  output logic [1:0]               state
);

  localparam int c_slot_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_idx_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_cnt_w  = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

  generate
    if (NUM_CH > DIV - 2) begin : g_cfg_check
      $error("dc_filter_sched: NUM_CH must not exceed DIV-2");
    end
  endgenerate

  logic [c_slot_w-1:0]     r_slot;
  logic                    r_strobe;
  logic                    r_valid;
  logic [NUM_CH*IN_W-1:0]  r_cap;
  dc_state_e               r_state;
  dc_state_e               w_state_nxt;
  logic [c_cnt_w-1:0]      r_frame_cnt;
  logic signed [IN_W-1:0]  r_out [NUM_CH];

  logic                    w_slot0, w_last_slot, w_frame_end, w_settle_done;
  logic                    w_clr, w_cnt_clr, w_cnt_inc, w_proc, w_acc_we;
  logic [c_idx_w-1:0]      w_ch;
  int                      w_shift;
  logic signed [IN_W-1:0]  w_x, w_y;
  logic signed [ACC_W-1:0] w_acc_rd, w_dc, w_acc_nxt;
  logic signed [63:0]      w_diff, w_sum;

  assign w_slot0       = (r_slot == '0);
  assign w_last_slot   = (r_slot == c_slot_w'(DIV - 1));
  assign w_frame_end   = (r_slot == c_slot_w'(NUM_CH));
  assign w_settle_done = (r_frame_cnt == c_cnt_w'(SETTLE_FRAMES - 1));

  // Reset parks the divider on the last slot so the first strobe follows release.
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      r_slot   <= c_slot_w'(DIV - 1);
      r_strobe <= 1'b0;
    end else begin
      r_slot   <= w_last_slot ? '0 : r_slot + c_slot_w'(1);
      r_strobe <= w_last_slot;
    end
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset)        r_cap <= '0;
    else if (w_slot0) r_cap <= c_data;
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (w_slot0) begin
      if (!en) begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
        w_cnt_clr   = 1'b1;
      end else if (restart || r_state == IDLE) begin
        w_state_nxt = SETTLE;
        w_cnt_clr   = 1'b1;
      end else if (r_state == TRACK && freeze) begin
        w_state_nxt = FREEZE;
      end else if (r_state == FREEZE && !freeze) begin
        w_state_nxt = TRACK;
      end
    end else if (w_frame_end && r_state == SETTLE) begin
      if (w_settle_done) w_state_nxt = TRACK;
      else               w_cnt_inc   = 1'b1;
    end
  end

  always_comb begin
    w_proc   = (r_state != IDLE) && !w_slot0 && (r_slot <= c_slot_w'(NUM_CH));
    w_acc_we = w_proc && (r_state == SETTLE || r_state == TRACK);
    w_shift  = (r_state == SETTLE) ? (K_SLOW - K_FAST) : 0;
    w_ch     = c_idx_w'(r_slot - c_slot_w'(1));
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset)          r_frame_cnt <= '0;
    else if (w_cnt_clr) r_frame_cnt <= '0;
    else if (w_cnt_inc) r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
  end

  // Shared datapath; the difference is formed wide so the clamp never sees a wrapped value.
  always_comb begin
    w_x = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_ch == c_idx_w'(i)) w_x = r_cap[i*IN_W +: IN_W];
    w_dc      = w_acc_rd >>> K_SLOW;
    w_diff    = 64'(w_x) - 64'(w_dc);
    w_y       = IN_W'(sat_in(w_diff, IN_W));
    w_sum     = 64'(w_acc_rd) + (64'(w_y) <<< w_shift);
    w_acc_nxt = ACC_W'(sat_acc(w_sum, ACC_W));
  end

  dc_acc_bank #(
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W),
    .IDX_W  (c_idx_w)
  ) u_acc_bank (
    .clk   (CLK_24M),
    .rst   (reset),
    .clr   (w_clr),
    .we    (w_acc_we),
    .idx   (w_ch),
    .wdata (w_acc_nxt),
    .rdata (w_acc_rd)
  );

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_out[i] <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_clr) begin
        for (int i = 0; i < NUM_CH; i++) r_out[i] <= '0;
      end else if (w_proc) begin
        for (int i = 0; i < NUM_CH; i++)
          if (w_ch == c_idx_w'(i)) r_out[i] <= w_y;
      end
      r_valid <= w_proc && w_frame_end;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign o_data[g*IN_W +: IN_W] = r_out[g];
    end
  endgenerate

  assign enable_3M = r_strobe;
  assign o_valid   = r_valid;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dc_filter_sched.sv
`default_nettype none
// ==== tb_dc_filter_sched : randomized frame-level reference-model bench for dc_filter_sched (rev 1.0) ====
module tb_dc_filter_sched;

  localparam int NUM_CH = 4;
  localparam int DIV    = 8;
  localparam int IN_W   = 9;
  localparam int ACC_W  = 32;
  localparam int K_FAST = 6;
  localparam int K_SLOW = 14;
  localparam int SF     = 512;

  logic                   clk;
  logic                   rst = 1'b1;
  logic                   en = 1'b0, restart = 1'b0, freeze = 1'b0;
  logic [NUM_CH*IN_W-1:0] c_data = '0;
  logic [NUM_CH*IN_W-1:0] o_data;
  logic                   enable_3M, o_valid;
  logic [1:0]             state;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model state
  int     m_st, m_st_start, m_cnt;
  bit     m_active;
  longint m_acc [NUM_CH];
  longint m_out [NUM_CH];
  int     m_x   [NUM_CH];

  dc_filter_sched #(
    .NUM_CH(NUM_CH), .DIV(DIV), .IN_W(IN_W), .ACC_W(ACC_W),
    .K_FAST(K_FAST), .K_SLOW(K_SLOW), .SETTLE_FRAMES(SF)
  ) u_dut (
    .CLK_24M(clk), .reset(rst), .en(en), .restart(restart), .freeze(freeze),
    .c_data(c_data), .enable_3M(enable_3M), .o_data(o_data), .o_valid(o_valid), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int och(input int c);
    logic signed [IN_W-1:0] v;
    v = o_data[c*IN_W +: IN_W];
    return int'(v);
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int rand_in();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin m_acc[c] = 0; m_out[c] = 0; end
  endfunction

  // One enable_3M frame: control decision, then every channel y = sat(x - dc), then settle bookkeeping.
  function automatic void model_frame(input bit e, input bit r, input bit f);
    longint dc, y, gain, lo, hi;
    lo = -(64'sd1 << (ACC_W - 1));
    hi = (64'sd1 << (ACC_W - 1)) - 1;
    if (!e) begin
      model_reset();
    end else if (r || m_st == 0) begin
      m_st = 1; m_cnt = 0;
    end else if (m_st == 2 && f) begin
      m_st = 3;
    end else if (m_st == 3 && !f) begin
      m_st = 2;
    end
    m_st_start = m_st;
    m_active   = (m_st != 0);
    if (m_active) begin
      for (int c = 0; c < NUM_CH; c++) begin
        dc = floor_div(m_acc[c], 64'sd1 << K_SLOW);
        y  = clamp(longint'(m_x[c]) - dc, -256, 255);
        m_out[c] = y;
        if (m_st == 1 || m_st == 2) begin
          gain = (m_st == 1) ? (64'sd1 << (K_SLOW - K_FAST)) : 64'sd1;
          m_acc[c] = clamp(m_acc[c] + y * gain, lo, hi);
        end
      end
    end
    if (m_st == 1) begin
      if (m_cnt == SF - 1) m_st = 2;
      else m_cnt++;
    end
  endfunction

  // Drives the frame's controls at slot 0, scrambles them mid-frame, and checks every slot.
  task automatic run_frame(input bit e, input bit r, input bit f);
    @(negedge clk);
    check("strobe_s0", enable_3M, 1);
    check("novalid_s0", o_valid, 0);
    en = e; restart = r; freeze = f;
    for (int c = 0; c < NUM_CH; c++) c_data[c*IN_W +: IN_W] = IN_W'(m_x[c]);
    model_frame(e, r, f);
    for (int s = 1; s < DIV; s++) begin
      @(negedge clk);
      check("strobe", enable_3M, 0);
      check("state", state, (s <= NUM_CH) ? m_st_start : m_st);
      if (s >= 2 && s <= NUM_CH + 1) check("ch_out", och(s - 2), m_out[s - 2]);
      check("valid", o_valid, (s == NUM_CH + 1) ? m_active : 1'b0);
      if (s == 3) begin
        en = ~en; restart = 1'($urandom); freeze = 1'($urandom);
        c_data = (NUM_CH*IN_W)'({$urandom, $urandom});
      end
    end
  endtask

  task automatic reset_midframe();
    @(negedge clk);
    en = 1'b1; restart = 1'b0; freeze = 1'b0;
    c_data = (NUM_CH*IN_W)'({$urandom, $urandom});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_odata", o_data, 0);
    check("rstmid_valid", o_valid, 0);
    check("rstmid_state", state, 0);
    check("rstmid_strobe", enable_3M, 0);
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      check("rstmid_novalid", o_valid, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  function automatic void pattern_x(input int k);
    m_x[0] = 15;
    m_x[1] = $rtoi(100.0 * $sin(2.0 * 3.14159265 * k / 48.0)) + 15 + int'($urandom_range(0, 2)) - 1;
    m_x[3] = rand_in();
  endfunction

  initial begin
    int prev, cur, k;
    int hold [NUM_CH];
    model_reset();
    for (int c = 0; c < NUM_CH; c++) m_x[c] = 0;
    repeat (3) @(negedge clk);
    check("rst_strobe", enable_3M, 0);
    check("rst_valid", o_valid, 0);
    check("rst_state", state, 0);
    check("rst_odata", o_data, 0);
    rst = 1'b0;

    // Idle with en low
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame(1'b0, 1'b0, 1'b0);
    end

    // Settle: constant, sine and negative full scale; freeze is ignored in SETTLE
    k = 0;
    m_x[2] = -256;
    for (int i = 0; i < SF + 20; i++) begin
      pattern_x(k++);
      run_frame(1'b1, 1'b0, (i < SF / 2) ? 1'($urandom) : 1'b0);
      if (i == 0) check("first_ch0", och(0), 15);
    end
    check("settled_state", state, 2);
    check("settled_ch0_small", (och(0) <= 1 && och(0) >= -1), 1);

    // Step ch2 to +255 after a restart; output saturates then decays monotonically
    m_x[2] = 255;
    pattern_x(k++);
    run_frame(1'b1, 1'b1, 1'b0);
    check("step_sat_ch2", och(2), 255);
    prev = och(2);
    for (int i = 0; i < 150; i++) begin
      pattern_x(k++);
      run_frame(1'b1, 1'b0, 1'b0);
      cur = och(2);
      check("mono_ch2", (cur <= prev), 1);
      prev = cur;
    end
    for (int i = 0; i < SF; i++) begin
      pattern_x(k++);
      run_frame(1'b1, 1'b0, 1'b0);
    end
    check("track_state", state, 2);

    // Freeze: identical input at start and end must give identical output
    m_x[0] = 37; m_x[1] = -120; m_x[2] = 200; m_x[3] = -5;
    run_frame(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < NUM_CH; c++) hold[c] = och(c);
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame(1'b1, 1'b0, 1'b1);
    end
    m_x[0] = 37; m_x[1] = -120; m_x[2] = 200; m_x[3] = -5;
    run_frame(1'b1, 1'b0, 1'b1);
    check("freeze_state", state, 3);
    for (int c = 0; c < NUM_CH; c++) check("freeze_hold", och(c), hold[c]);

    // Unfreeze and track
    for (int i = 0; i < 50; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame(1'b1, 1'b0, 1'b0);
      if (i == 0) check("unfreeze_state", state, 2);
    end

    // Random control traffic
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame($urandom_range(0, 15) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0);
    end

    // Drop en: the running frame completes, the next one clears everything
    for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    check("drop_en_state", state, 0);
    check("drop_en_odata", o_data, 0);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame(1'b1, 1'b0, 1'b0);
    end
    reset_midframe();
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NUM_CH; c++) m_x[c] = rand_in();
      run_frame(1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
